sd_sector_buffer: RTL and testbench
===================================

SD_SECTOR_BUFFER -- requirements
Module: sd_sector_buffer

Interface
REQ-001 Parameter TOKEN_TIMEOUT, default 12'd4095: maximum number of 0xFF poll bytes accepted before the start token.
REQ-002 Port CLOCK_50, input, 1: sole clock; all state changes on its rising edge.
REQ-003 Port nRESET, input, 1: reset, asynchronous, active-low.
REQ-004 Port START, input, 1: one-cycle pulse; begins capture of one 512-byte sector.
REQ-005 Port XFER_REQ, output, 1: one-cycle pulse requesting one 0xFF byte exchange from the SPI byte engine.
REQ-006 Port XFER_DONE, input, 1: one-cycle pulse from the SPI byte engine; RX_BYTE valid in the same cycle.
REQ-007 Port RX_BYTE, input, 8: byte received from the card.
REQ-008 Port RD, input, 1: one-cycle pulse; host read of the next buffered word.
REQ-009 Port RD_DATA, output, 16: registered word at the current read pointer.
REQ-010 Port BUSY, output, 1: high while in WAIT_TOKEN, DATA, CRC_HI or CRC_LO.
REQ-011 Port READY, output, 1: high in DONE (sector captured, buffer readable).
REQ-012 Port CRC_OK, output, 1: valid while READY; 1 when the received CRC equals the computed CRC.
REQ-013 Port ERR, output, 2: 00 none, 01 token timeout, 10 data-error token; valid in ERROR.

Function
REQ-014 States: IDLE, WAIT_TOKEN, DATA, CRC_HI, CRC_LO, DONE, ERROR.
REQ-015 IDLE, DONE or ERROR + START: clear poll counter, byte counter, write pointer, read pointer and CRC; go to WAIT_TOKEN; assert XFER_REQ on the next cycle.
REQ-016 START in WAIT_TOKEN, DATA, CRC_HI or CRC_LO: ignored.
REQ-017 Exactly one XFER_REQ outstanding at a time; the next XFER_REQ is issued the cycle after each XFER_DONE while the state still requires bytes.
REQ-018 XFER_DONE with no request outstanding: ignored.
REQ-019 WAIT_TOKEN, RX_BYTE = 0xFE: go to DATA.
REQ-020 WAIT_TOKEN, RX_BYTE = 0xFF: increment poll counter.
REQ-021 WAIT_TOKEN, poll counter reaches TOKEN_TIMEOUT: go to ERROR with ERR = 01.
REQ-022 WAIT_TOKEN, any other RX_BYTE: go to ERROR with ERR = 10.
REQ-023 DATA: bytes pack big-endian; even byte = word[15:8], odd byte = word[7:0].
REQ-024 DATA: on each odd byte, write the word to a 256x16 buffer at the write pointer, then increment the write pointer (8-bit).
REQ-025 DATA: after byte 511 (9-bit counter), go to CRC_HI.
REQ-026 CRC: CRC16-CCITT, polynomial 0x1021, init 0x0000, MSB-first, over the 512 data bytes only; one byte per XFER_DONE, combinational 8-bit step.
REQ-027 CRC_HI: latch received CRC[15:8]; go to CRC_LO.
REQ-028 CRC_LO: latch received CRC[7:0]; set CRC_OK = (received == computed); go to DONE; issue no further XFER_REQ.
REQ-029 DONE/ERROR: hold state until START.
REQ-030 RD_DATA: updated one cycle after reset or START (word 0), and one cycle after each accepted RD, from buffer[read pointer].
REQ-031 RD accepted only while READY; each accepted RD increments the read pointer by one; RD_DATA then shows the new word one cycle later.
REQ-032 Read pointer wraps 255 -> 0.
REQ-033 RD outside DONE: ignored; RD_DATA holds.
REQ-034 START and RD in the same cycle: START wins; RD is discarded.
REQ-035 Buffer contents persist across START until overwritten.

Reset
REQ-036 nRESET low, asynchronous: state IDLE; XFER_REQ 0; BUSY 0; READY 0; CRC_OK 0; ERR 00; RD_DATA 16'h0000; all counters and pointers 0.
REQ-037 Reset asserted mid-sector aborts the capture; no XFER_REQ after release until START.
REQ-038 Buffer RAM contents are not reset.

Verification
REQ-039 START; engine returns 3x 0xFF, 0xFE, bytes 0x00..0xFF twice, CRC 0x7FA1 -> READY = 1, CRC_OK = 0; successive RD_DATA values 0x0001, 0x0203, ... 0xFEFF, then 0x0001 again after 256 reads.
REQ-040 START; 0xFE; 512x 0xFF; CRC 0x7FA1 -> CRC_OK = 1; all words 0xFFFF.
REQ-041 START; 4095 polls of 0xFF -> ERROR, ERR = 01, BUSY = 0, exactly 4095 XFER_REQ pulses.
REQ-042 START; 0xFF, 0x05 -> ERROR, ERR = 10 after the 2nd byte.
REQ-043 nRESET pulsed low after data byte 100 -> all outputs at reset values immediately; no XFER_REQ until a new START; a full sector then completes normally.
REQ-044 In DONE, START and RD in the same cycle -> WAIT_TOKEN, read pointer 0, RD_DATA = word 0.

Source files
------------

// File: rtl/sd_sector_buffer.sv
// SD card single-sector read buffer: polls for the start token, captures 512 data bytes
// into a 256x16 RAM with CRC16-CCITT checking, then serves the words to the host.
module sd_sector_buffer #(
    parameter logic [11:0] TOKEN_TIMEOUT = 12'd4095
) (
    input  logic        CLOCK_50,
    input  logic        nRESET,
    input  logic        START,
    output logic        XFER_REQ,
    input  logic        XFER_DONE,
    input  logic [7:0]  RX_BYTE,
    input  logic        RD,
    output logic [15:0] RD_DATA,
    output logic        BUSY,
    output logic        READY,
    output logic        CRC_OK,
    output logic [1:0]  ERR
);

    typedef enum logic [2:0] {
        StIdle, StWaitToken, StData, StCrcHi, StCrcLo, StDone, StError
    } state_t;

    state_t      state;
    logic [11:0] poll_cnt;
    logic [8:0]  byte_cnt;
    logic [7:0]  wr_ptr;
    logic [7:0]  rd_ptr;
    logic [15:0] crc;
    logic [7:0]  crc_rx_hi;
    logic [7:0]  hi_byte;
    logic        pending;
    logic        rd_load;
    logic [15:0] mem [256];

    logic accept;
    logic can_start;
    logic mem_we;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    assign accept    = XFER_DONE && pending;
    assign can_start = (state == StIdle) || (state == StDone) || (state == StError);
    // START pre-empts a byte that lands in the same cycle only outside capture, so no overlap.
    assign mem_we    = accept && (state == StData) && byte_cnt[0];

    always_ff @(posedge CLOCK_50) begin
        if (mem_we) mem[wr_ptr] <= {hi_byte, RX_BYTE};
    end

    always_ff @(posedge CLOCK_50 or negedge nRESET) begin
        if (!nRESET) begin
            state     <= StIdle;
            poll_cnt  <= 12'd0;
            byte_cnt  <= 9'd0;
            wr_ptr    <= 8'd0;
            rd_ptr    <= 8'd0;
            crc       <= 16'h0000;
            crc_rx_hi <= 8'h00;
            hi_byte   <= 8'h00;
            pending   <= 1'b0;
            rd_load   <= 1'b1;
            XFER_REQ  <= 1'b0;
            RD_DATA   <= 16'h0000;
            BUSY      <= 1'b0;
            READY     <= 1'b0;
            CRC_OK    <= 1'b0;
            ERR       <= 2'b00;
        end else begin
            XFER_REQ <= 1'b0;
            rd_load  <= 1'b0;
            if (rd_load) RD_DATA <= mem[rd_ptr];

            if (START && can_start) begin
                state    <= StWaitToken;
                poll_cnt <= 12'd0;
                byte_cnt <= 9'd0;
                wr_ptr   <= 8'd0;
                rd_ptr   <= 8'd0;
                crc      <= 16'h0000;
                XFER_REQ <= 1'b1;
                pending  <= 1'b1;
                BUSY     <= 1'b1;
                READY    <= 1'b0;
                CRC_OK   <= 1'b0;
                ERR      <= 2'b00;
                RD_DATA  <= mem[8'd0];
            end else begin
                if (RD && state == StDone) begin
                    rd_ptr  <= rd_ptr + 8'd1;
                    RD_DATA <= mem[rd_ptr + 8'd1];
                end
                if (accept) begin
                    pending <= 1'b0;
                    unique case (state)
                        StWaitToken: begin
                            if (RX_BYTE == 8'hFE) begin
                                state    <= StData;
                                XFER_REQ <= 1'b1;
                                pending  <= 1'b1;
                            end else if (RX_BYTE == 8'hFF) begin
                                if (poll_cnt + 12'd1 == TOKEN_TIMEOUT) begin
                                    state <= StError;
                                    ERR   <= 2'b01;
                                    BUSY  <= 1'b0;
                                end else begin
                                    poll_cnt <= poll_cnt + 12'd1;
                                    XFER_REQ <= 1'b1;
                                    pending  <= 1'b1;
                                end
                            end else begin
                                state <= StError;
                                ERR   <= 2'b10;
                                BUSY  <= 1'b0;
                            end
                        end
                        StData: begin
                            crc      <= crc16_step(crc, RX_BYTE);
                            byte_cnt <= byte_cnt + 9'd1;
                            if (byte_cnt[0]) wr_ptr <= wr_ptr + 8'd1;
                            else             hi_byte <= RX_BYTE;
                            if (byte_cnt == 9'd511) state <= StCrcHi;
                            XFER_REQ <= 1'b1;
                            pending  <= 1'b1;
                        end
                        StCrcHi: begin
                            crc_rx_hi <= RX_BYTE;
                            state     <= StCrcLo;
                            XFER_REQ  <= 1'b1;
                            pending   <= 1'b1;
                        end
                        StCrcLo: begin
                            CRC_OK  <= ({crc_rx_hi, RX_BYTE} == crc);
                            state   <= StDone;
                            BUSY    <= 1'b0;
                            READY   <= 1'b1;
                            RD_DATA <= mem[rd_ptr];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Bench for sd_sector_buffer: table of sector scenarios driven through a byte-engine model,
// plus hand-written sequences for timeout, START/RD collision and mid-sector reset.
module tb_sd_sector_buffer;

    logic        CLOCK_50;
    logic        nRESET;
    logic        START;
    logic        XFER_REQ;
    logic        XFER_DONE;
    logic [7:0]  RX_BYTE;
    logic        RD;
    logic [15:0] RD_DATA;
    logic        BUSY;
    logic        READY;
    logic        CRC_OK;
    logic [1:0]  ERR;

    sd_sector_buffer #(.TOKEN_TIMEOUT(12'd4095)) dut (
        .CLOCK_50  (CLOCK_50),
        .nRESET    (nRESET),
        .START     (START),
        .XFER_REQ  (XFER_REQ),
        .XFER_DONE (XFER_DONE),
        .RX_BYTE   (RX_BYTE),
        .RD        (RD),
        .RD_DATA   (RD_DATA),
        .BUSY      (BUSY),
        .READY     (READY),
        .CRC_OK    (CRC_OK),
        .ERR       (ERR)
    );

    typedef struct {
        int          polls;
        logic [7:0]  tok;
        int          mode;     // 0: bytes 0x00..0xFF twice, 1: all 0xFF
        logic [15:0] crc;
        logic        exp_ok;
        logic [1:0]  exp_err;
        logic [15:0] exp_w0;
    } vec_t;

    vec_t vecs[5];
    int   checks = 0;
    int   failures = 0;
    int   req_cnt = 0;
    bit   stuck = 0;

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    always @(negedge CLOCK_50) if (XFER_REQ === 1'b1) req_cnt++;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ramp_word(input int j);
        logic [7:0] b;
        b = 8'((j * 2) & 255);
        return {b, b + 8'd1};
    endfunction

    // Byte-engine model: wait for a request, answer two cycles later.
    task automatic send_byte(input logic [7:0] b);
        int n;
        if (stuck) return;
        n = 0;
        while (XFER_REQ !== 1'b1 && n < 20) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (XFER_REQ !== 1'b1) begin
            checks++;
            failures++;
            stuck = 1;
            $display("FAIL xfer_req_wait: got no request expected request within 20 cycles");
            return;
        end
        @(negedge CLOCK_50);
        XFER_DONE = 1'b1;
        RX_BYTE   = b;
        @(negedge CLOCK_50);
        XFER_DONE = 1'b0;
        RX_BYTE   = 8'h00;
    endtask

    task automatic pulse_start();
        @(negedge CLOCK_50);
        START = 1'b1;
        @(negedge CLOCK_50);
        START = 1'b0;
    endtask

    task automatic pulse_rd();
        @(negedge CLOCK_50);
        RD = 1'b1;
        @(negedge CLOCK_50);
        RD = 1'b0;
    endtask

    task automatic run_sector(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        pulse_start();
        check({tag, "_busy_start"}, {15'd0, BUSY}, 16'd1);
        for (int i = 0; i < v.polls; i++) send_byte(8'hFF);
        send_byte(v.tok);
        if (v.tok != 8'hFE) begin
            check({tag, "_err"}, {14'd0, ERR}, {14'd0, v.exp_err});
            check({tag, "_err_busy"}, {15'd0, BUSY}, 16'd0);
            check({tag, "_err_ready"}, {15'd0, READY}, 16'd0);
            check({tag, "_err_rd_data"}, RD_DATA, v.exp_w0);
            pulse_rd();
            check({tag, "_rd_ignored"}, RD_DATA, v.exp_w0);
            return;
        end
        for (int k = 0; k < 512; k++) send_byte((v.mode == 0) ? 8'(k & 255) : 8'hFF);
        send_byte(v.crc[15:8]);
        send_byte(v.crc[7:0]);
        check({tag, "_ready"}, {15'd0, READY}, 16'd1);
        check({tag, "_busy_done"}, {15'd0, BUSY}, 16'd0);
        check({tag, "_crc_ok"}, {15'd0, CRC_OK}, {15'd0, v.exp_ok});
        check({tag, "_err_none"}, {14'd0, ERR}, 16'd0);
        check({tag, "_word0"}, RD_DATA, v.exp_w0);
        for (int i = 0; i < 256; i++) begin
            pulse_rd();
            check($sformatf("%s_word%0d", tag, (i + 1) % 256), RD_DATA,
                  (v.mode == 0) ? ramp_word((i + 1) % 256) : 16'hFFFF);
        end
    endtask

    initial begin
        int base;
        vecs[0] = '{polls: 3, tok: 8'hFE, mode: 0, crc: 16'h7FA1, exp_ok: 1'b0, exp_err: 2'b00,
                    exp_w0: 16'h0001};
        vecs[1] = '{polls: 0, tok: 8'hFE, mode: 1, crc: 16'h7FA1, exp_ok: 1'b1, exp_err: 2'b00,
                    exp_w0: 16'hFFFF};
        vecs[2] = '{polls: 1, tok: 8'h05, mode: 1, crc: 16'h0000, exp_ok: 1'b0, exp_err: 2'b10,
                    exp_w0: 16'hFFFF};
        vecs[3] = '{polls: 0, tok: 8'h00, mode: 1, crc: 16'h0000, exp_ok: 1'b0, exp_err: 2'b10,
                    exp_w0: 16'hFFFF};
        vecs[4] = '{polls: 2, tok: 8'hFE, mode: 1, crc: 16'h7FA0, exp_ok: 1'b0, exp_err: 2'b00,
                    exp_w0: 16'hFFFF};

        nRESET = 1'b0; START = 1'b0; XFER_DONE = 1'b0; RX_BYTE = 8'h00; RD = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_xfer_req", {15'd0, XFER_REQ}, 16'd0);
        check("rst_busy", {15'd0, BUSY}, 16'd0);
        check("rst_ready", {15'd0, READY}, 16'd0);
        check("rst_crc_ok", {15'd0, CRC_OK}, 16'd0);
        check("rst_err", {14'd0, ERR}, 16'd0);
        check("rst_rd_data", RD_DATA, 16'h0000);
        nRESET = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        // Unsolicited XFER_DONE in IDLE must not start anything.
        base = req_cnt;
        XFER_DONE = 1'b1; RX_BYTE = 8'hFE;
        @(negedge CLOCK_50);
        XFER_DONE = 1'b0; RX_BYTE = 8'h00;
        repeat (3) @(negedge CLOCK_50);
        check("stray_done_busy", {15'd0, BUSY}, 16'd0);
        check("stray_done_req", 16'(req_cnt - base), 16'd0);

        for (int i = 0; i < 5; i++) run_sector(vecs[i], i);

        // START and RD together in DONE: START wins, pointer back to word 0.
        run_sector(vecs[0], 5);
        repeat (3) pulse_rd();
        check("pre_collide_word3", RD_DATA, 16'h0607);
        base = req_cnt;
        @(negedge CLOCK_50);
        START = 1'b1; RD = 1'b1;
        @(negedge CLOCK_50);
        START = 1'b0; RD = 1'b0;
        check("collide_busy", {15'd0, BUSY}, 16'd1);
        check("collide_ready", {15'd0, READY}, 16'd0);
        check("collide_word0", RD_DATA, 16'h0001);

        // Token timeout from that WAIT_TOKEN.
        for (int i = 0; i < 4095; i++) send_byte(8'hFF);
        check("timeout_err", {14'd0, ERR}, 16'd1);
        check("timeout_busy", {15'd0, BUSY}, 16'd0);
        repeat (10) @(negedge CLOCK_50);
        check("timeout_req_count", 16'(req_cnt - base), 16'd4095);

        // Reset in the middle of the data phase.
        pulse_start();
        send_byte(8'hFE);
        for (int k = 0; k <= 100; k++) send_byte(8'(k));
        nRESET = 1'b0;
        #1;
        check("mid_rst_xfer_req", {15'd0, XFER_REQ}, 16'd0);
        check("mid_rst_busy", {15'd0, BUSY}, 16'd0);
        check("mid_rst_ready", {15'd0, READY}, 16'd0);
        check("mid_rst_err", {14'd0, ERR}, 16'd0);
        check("mid_rst_rd_data", RD_DATA, 16'h0000);
        @(negedge CLOCK_50);
        nRESET = 1'b1;
        base = req_cnt;
        repeat (2) @(negedge CLOCK_50);
        check("post_rst_word0", RD_DATA, 16'h0001);
        repeat (20) @(negedge CLOCK_50);
        check("post_rst_no_req", 16'(req_cnt - base), 16'd0);
        check("post_rst_busy", {15'd0, BUSY}, 16'd0);
        run_sector(vecs[1], 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
